// File: rtl/alu_ctrl_pipe_if.sv
// Handshake and control bundle between ID/EX decode, the ALU control stage and its consumers.
// The stage itself takes the slave side; whoever drives ops and drains results takes master.
interface alu_ctrl_pipe_if #(
   parameter int CTRL_W = 4
);
   logic              up_valid;
   logic              up_ready;
   logic [5:0]        funct;
   logic [2:0]        alu_op;
   logic              dn_valid;
   logic              dn_ready;
   logic [CTRL_W-1:0] alu_ctrl;
   logic              reg_write;
   logic              jr;
   logic              hilo_we;
   logic              md_start;
   logic              md_busy;
   logic              illegal;

   modport slave (
      input  up_valid, funct, alu_op, dn_ready,
      output up_ready, dn_valid, alu_ctrl, reg_write, jr, hilo_we, md_start, md_busy, illegal
   );

   modport master (
      output up_valid, funct, alu_op, dn_ready,
      input  up_ready, dn_valid, alu_ctrl, reg_write, jr, hilo_we, md_start, md_busy, illegal
   );
endinterface

// File: rtl/alu_ctrl_pipe.sv
// Registered ALU control stage: decodes ALUOp/funct into a one-slot output bundle and
// sequences multi-cycle mult/div through an IDLE/BUSY FSM with a down-counter.
module alu_ctrl_pipe #(
   parameter int CTRL_W = 4,
   parameter int MD_LAT = 4,
   parameter int CNT_W  = 3
) (
   input logic            clk_i,
   input logic            rst_i,
   alu_ctrl_pipe_if.slave bus
);

   localparam logic [CTRL_W-1:0] OP_AND  = CTRL_W'(4'b0000);
   localparam logic [CTRL_W-1:0] OP_OR   = CTRL_W'(4'b0001);
   localparam logic [CTRL_W-1:0] OP_ADD  = CTRL_W'(4'b0010);
   localparam logic [CTRL_W-1:0] OP_SUB  = CTRL_W'(4'b0110);
   localparam logic [CTRL_W-1:0] OP_SLT  = CTRL_W'(4'b0111);
   localparam logic [CTRL_W-1:0] OP_MULT = CTRL_W'(4'b1000);
   localparam logic [CTRL_W-1:0] OP_DIV  = CTRL_W'(4'b1001);
   localparam logic [CTRL_W-1:0] OP_MFHI = CTRL_W'(4'b1010);
   localparam logic [CTRL_W-1:0] OP_MFLO = CTRL_W'(4'b1011);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic [CTRL_W-1:0] md_ctrl;
   logic [CTRL_W-1:0] dec_ctrl;
   logic              dec_rw, dec_jr, dec_illegal, dec_md;
   logic              slot_free, accept, load_single, load_md;

   // Combinational decode of the op presented upstream.
   always_comb begin
      // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
      dec_ctrl    = '0;
      dec_rw      = 1'b0;
      dec_jr      = 1'b0;
      dec_illegal = 1'b0;
      dec_md      = 1'b0;
      case (bus.alu_op)
         3'b000, 3'b011: begin dec_ctrl = OP_ADD; dec_rw = 1'b1; end
         3'b001, 3'b101: dec_ctrl = OP_SUB;
         3'b100:         begin dec_ctrl = OP_SLT; dec_rw = 1'b1; end
         3'b110:         begin dec_ctrl = OP_AND; dec_rw = 1'b1; end
         3'b111:         begin dec_ctrl = OP_OR;  dec_rw = 1'b1; end
         3'b010: begin
            case (bus.funct)
               6'b100000: begin dec_ctrl = OP_ADD;  dec_rw = 1'b1; end
               6'b100010: begin dec_ctrl = OP_SUB;  dec_rw = 1'b1; end
               6'b100100: begin dec_ctrl = OP_AND;  dec_rw = 1'b1; end
               6'b100101: begin dec_ctrl = OP_OR;   dec_rw = 1'b1; end
               6'b101010: begin dec_ctrl = OP_SLT;  dec_rw = 1'b1; end
               6'b001000: begin dec_ctrl = OP_ADD;  dec_jr = 1'b1; end
               6'b010000: begin dec_ctrl = OP_MFHI; dec_rw = 1'b1; end
               6'b010010: begin dec_ctrl = OP_MFLO; dec_rw = 1'b1; end
               6'b011000: begin dec_ctrl = OP_MULT; dec_md = 1'b1; end
               6'b011010: begin dec_ctrl = OP_DIV;  dec_md = 1'b1; end
               default:   dec_illegal = 1'b1;
            endcase
         end
         default: ;
      endcase
   end

   assign slot_free = !bus.dn_valid || bus.dn_ready;
   assign accept    = bus.up_valid && bus.up_ready;

   // FSM state register.
   always_ff @(posedge clk_i) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (rst_i) begin
         state   <= IDLE;
         cnt     <= '0;
         md_ctrl <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (accept && dec_md) md_ctrl <= dec_ctrl;
      end
   end

   // FSM next state: count down from MD_LAT-1, then wait at zero until the slot frees.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      load_md   = 1'b0;
      case (state)
         IDLE: begin
            if (accept && dec_md) begin
               state_nxt = BUSY;
               cnt_nxt   = CNT_W'(MD_LAT - 1);
            end
         end
         BUSY: begin
            if (cnt != '0) begin
               cnt_nxt = cnt - CNT_W'(1);
            end else if (slot_free) begin
               load_md   = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // FSM outputs; busy covers the BUSY cycles after the start pulse.
   always_comb begin
      bus.up_ready = slot_free && (state == IDLE) && !rst_i;
      bus.md_busy  = (state == BUSY) && !bus.md_start;
      load_single  = accept && !dec_md;
   end

   // Output bundle slot: holds while stalled, fields persist after drain except hilo_we.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         bus.dn_valid  <= 1'b0;
         bus.alu_ctrl  <= '0;
         bus.reg_write <= 1'b0;
         bus.jr        <= 1'b0;
         bus.hilo_we   <= 1'b0;
         bus.illegal   <= 1'b0;
         bus.md_start  <= 1'b0;
      end else begin
         bus.md_start <= accept && dec_md;
         if (load_single) begin
            bus.dn_valid  <= 1'b1;
            bus.alu_ctrl  <= dec_ctrl;
            bus.reg_write <= dec_rw;
            bus.jr        <= dec_jr;
            bus.illegal   <= dec_illegal;
            bus.hilo_we   <= 1'b0;
         end else if (load_md) begin
            bus.dn_valid  <= 1'b1;
            bus.alu_ctrl  <= md_ctrl;
            bus.reg_write <= 1'b0;
            bus.jr        <= 1'b0;
            bus.illegal   <= 1'b0;
            bus.hilo_we   <= 1'b1;
         end else if (bus.dn_ready) begin
            bus.dn_valid <= 1'b0;
            bus.hilo_we  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alu_ctrl_pipe.sv
// Bench for alu_ctrl_pipe: a transaction-level model checked every cycle, directed
// sequences with literal expectations, then randomized traffic with occasional resets.
module tb_alu_ctrl_pipe;
   localparam int CTRL_W = 4;
   localparam int MD_LAT = 4;
   localparam int CNT_W  = 3;

   logic clk_i = 1'b0;
   logic rst_i;
   always #5 clk_i = ~clk_i;

   alu_ctrl_pipe_if #(.CTRL_W(CTRL_W)) bus ();

   alu_ctrl_pipe #(.CTRL_W(CTRL_W), .MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at time %0t", name, act, exp, $time);
      end
   endtask

   typedef struct packed {
      logic [3:0] ctrl;
      logic       rw;
      logic       jr;
      logic       ill;
      logic       md;
   } dec_t;

   // Decode table written straight from the op/funct listing.
   function automatic dec_t decode(input logic [2:0] op, input logic [5:0] f);
      dec_t d;
      d = '0;
      case (op)
         3'b000, 3'b011: d = '{ctrl: 4'd2, rw: 1'b1, jr: 1'b0, ill: 1'b0, md: 1'b0};
         3'b001, 3'b101: d = '{ctrl: 4'd6, rw: 1'b0, jr: 1'b0, ill: 1'b0, md: 1'b0};
         3'b100:         d = '{ctrl: 4'd7, rw: 1'b1, jr: 1'b0, ill: 1'b0, md: 1'b0};
         3'b110:         d = '{ctrl: 4'd0, rw: 1'b1, jr: 1'b0, ill: 1'b0, md: 1'b0};
         3'b111:         d = '{ctrl: 4'd1, rw: 1'b1, jr: 1'b0, ill: 1'b0, md: 1'b0};
         default: begin
            case (f)
               6'b100000: d = '{ctrl: 4'd2,  rw: 1'b1, jr: 1'b0, ill: 1'b0, md: 1'b0};
               6'b100010: d = '{ctrl: 4'd6,  rw: 1'b1, jr: 1'b0, ill: 1'b0, md: 1'b0};
               6'b100100: d = '{ctrl: 4'd0,  rw: 1'b1, jr: 1'b0, ill: 1'b0, md: 1'b0};
               6'b100101: d = '{ctrl: 4'd1,  rw: 1'b1, jr: 1'b0, ill: 1'b0, md: 1'b0};
               6'b101010: d = '{ctrl: 4'd7,  rw: 1'b1, jr: 1'b0, ill: 1'b0, md: 1'b0};
               6'b001000: d = '{ctrl: 4'd2,  rw: 1'b0, jr: 1'b1, ill: 1'b0, md: 1'b0};
               6'b010000: d = '{ctrl: 4'd10, rw: 1'b1, jr: 1'b0, ill: 1'b0, md: 1'b0};
               6'b010010: d = '{ctrl: 4'd11, rw: 1'b1, jr: 1'b0, ill: 1'b0, md: 1'b0};
               6'b011000: d = '{ctrl: 4'd8,  rw: 1'b0, jr: 1'b0, ill: 1'b0, md: 1'b1};
               6'b011010: d = '{ctrl: 4'd9,  rw: 1'b0, jr: 1'b0, ill: 1'b0, md: 1'b1};
               default:   d = '{ctrl: 4'd0,  rw: 1'b0, jr: 1'b0, ill: 1'b1, md: 1'b0};
            endcase
         end
      endcase
      return d;
   endfunction

   // Model: one output slot plus at most one pending mult/div aged in cycles since accept.
   bit         model_on  = 1'b0;
   bit         m_valid   = 1'b0;
   dec_t       m_out     = '0;
   bit         m_hilo    = 1'b0;
   bit         m_pending = 1'b0;
   int         m_age     = 0;
   logic [3:0] m_md_ctrl = '0;

   always @(negedge clk_i) begin : model_p
      bit   slot_free;
      bit   exp_ready;
      bit   acc;
      bit   load;
      dec_t d;
      if (model_on) begin
         slot_free = !m_valid || bus.dn_ready;
         exp_ready = slot_free && !m_pending && !rst_i;
         check("ready", bus.up_ready, exp_ready);
         check("valid", bus.dn_valid, m_valid);
         check("md_start", bus.md_start, m_pending && (m_age == 1));
         check("md_busy", bus.md_busy, m_pending && (m_age >= 2));
         if (m_valid) begin
            check("alu_ctrl", bus.alu_ctrl, m_out.ctrl);
            check("reg_write", bus.reg_write, m_out.rw);
            check("jr", bus.jr, m_out.jr);
            check("illegal", bus.illegal, m_out.ill);
            check("hilo_we", bus.hilo_we, m_hilo);
         end else begin
            check("hilo_we_idle", bus.hilo_we, 1'b0);
         end

         if (rst_i) begin
            m_valid   = 1'b0;
            m_pending = 1'b0;
            m_age     = 0;
            m_hilo    = 1'b0;
         end else begin
            acc  = bus.up_valid && exp_ready;
            load = 1'b0;
            if (m_pending) begin
               if (m_age >= MD_LAT && slot_free) begin
                  m_out     = '{ctrl: m_md_ctrl, rw: 1'b0, jr: 1'b0, ill: 1'b0, md: 1'b1};
                  m_hilo    = 1'b1;
                  load      = 1'b1;
                  m_pending = 1'b0;
               end else begin
                  m_age++;
               end
            end
            if (acc) begin
               d = decode(bus.alu_op, bus.funct);
               if (d.md) begin
                  m_pending = 1'b1;
                  m_age     = 1;
                  m_md_ctrl = d.ctrl;
               end else begin
                  m_out  = d;
                  m_hilo = 1'b0;
                  load   = 1'b1;
               end
            end
            m_valid = load ? 1'b1 : (m_valid && !bus.dn_ready);
         end
      end
   end

   task automatic drive(input logic v, input logic [2:0] op, input logic [5:0] f);
      @(posedge clk_i);
      #1;
      bus.up_valid = v;
      bus.alu_op   = op;
      bus.funct    = f;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   logic [5:0] legal_f [10] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010,
                                 6'b001000, 6'b010000, 6'b010010, 6'b011000, 6'b011010};

   initial begin
      int starts, busys, first_valid;
      logic [3:0] res_ctrl;
      logic       res_hilo;
      int hilo_seen;

      bus.up_valid = 1'b0;
      bus.alu_op   = 3'b000;
      bus.funct    = 6'b000000;
      bus.dn_ready = 1'b1;
      rst_i        = 1'b1;
      @(posedge clk_i);
      #1;
      rst_i    = 1'b0;
      model_on = 1'b1;

      // Reset state.
      @(negedge clk_i);
      check("rst_valid", bus.dn_valid, 1'b0);
      check("rst_ctrl", bus.alu_ctrl, 4'd0);
      check("rst_rw", bus.reg_write, 1'b0);
      check("rst_jr", bus.jr, 1'b0);
      check("rst_hilo", bus.hilo_we, 1'b0);
      check("rst_start", bus.md_start, 1'b0);
      check("rst_busy", bus.md_busy, 1'b0);
      check("rst_illegal", bus.illegal, 1'b0);
      check("rst_ready", bus.up_ready, 1'b1);

      // Back-to-back sub then slt.
      drive(1'b1, 3'b010, 6'b100010);
      drive(1'b1, 3'b010, 6'b101010);
      @(negedge clk_i);
      check("b2b_sub_valid", bus.dn_valid, 1'b1);
      check("b2b_sub_ctrl", bus.alu_ctrl, 4'b0110);
      check("b2b_sub_rw", bus.reg_write, 1'b1);
      drive(1'b0, 3'b000, 6'b000000);
      @(negedge clk_i);
      check("b2b_slt_valid", bus.dn_valid, 1'b1);
      check("b2b_slt_ctrl", bus.alu_ctrl, 4'b0111);
      check("b2b_slt_rw", bus.reg_write, 1'b1);

      // Mult with no downstream stall.
      drive(1'b1, 3'b010, 6'b011000);
      drive(1'b0, 3'b000, 6'b000000);
      starts = 0; busys = 0; first_valid = 0; res_ctrl = '0; res_hilo = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk_i);
         if (k == 1) check("mult_ready_low", bus.up_ready, 1'b0);
         starts += int'(bus.md_start);
         busys  += int'(bus.md_busy);
         if (bus.dn_valid && first_valid == 0) begin
            first_valid = k;
            res_ctrl    = bus.alu_ctrl;
            res_hilo    = bus.hilo_we;
         end
      end
      check("mult_start_cycles", starts, 1);
      check("mult_busy_cycles", busys, 3);
      check("mult_result_cycle", first_valid, 5);
      check("mult_result_ctrl", res_ctrl, 4'b1000);
      check("mult_result_hilo", res_hilo, 1'b1);

      // Downstream stall: bundle holds, a waiting op is refused, then drain and accept coincide.
      @(posedge clk_i);
      #1;
      bus.up_valid = 1'b1; bus.alu_op = 3'b110; bus.funct = 6'b000000;
      bus.dn_ready = 1'b0;
      drive(1'b1, 3'b111, 6'b000000);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk_i);
         check("stall_valid", bus.dn_valid, 1'b1);
         check("stall_ctrl", bus.alu_ctrl, 4'b0000);
         check("stall_ready", bus.up_ready, 1'b0);
      end
      @(posedge clk_i);
      #1;
      bus.dn_ready = 1'b1;
      drive(1'b0, 3'b000, 6'b000000);
      @(negedge clk_i);
      check("drain_accept_valid", bus.dn_valid, 1'b1);
      check("drain_accept_ctrl", bus.alu_ctrl, 4'b0001);

      // Mult result arriving into a stalled downstream stays put until released.
      drive(1'b1, 3'b010, 6'b011000);
      @(posedge clk_i);
      #1;
      bus.up_valid = 1'b0;
      bus.dn_ready = 1'b0;
      repeat (MD_LAT + 4) @(negedge clk_i);
      check("mult_stall_valid", bus.dn_valid, 1'b1);
      check("mult_stall_ctrl", bus.alu_ctrl, 4'b1000);
      check("mult_stall_hilo", bus.hilo_we, 1'b1);
      @(posedge clk_i);
      #1;
      bus.dn_ready = 1'b1;

      // jr and an undefined funct.
      drive(1'b1, 3'b010, 6'b001000);
      drive(1'b1, 3'b010, 6'b111111);
      @(negedge clk_i);
      check("jr_jr", bus.jr, 1'b1);
      check("jr_rw", bus.reg_write, 1'b0);
      check("jr_ctrl", bus.alu_ctrl, 4'b0010);
      drive(1'b0, 3'b000, 6'b000000);
      @(negedge clk_i);
      check("ill_illegal", bus.illegal, 1'b1);
      check("ill_ctrl", bus.alu_ctrl, 4'b0000);
      check("ill_rw", bus.reg_write, 1'b0);

      // Reset while a div is counting (counter at 2): op abandoned, no result ever.
      drive(1'b1, 3'b010, 6'b011010);
      drive(1'b0, 3'b000, 6'b000000);
      @(posedge clk_i);
      #1;
      rst_i = 1'b1;
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      @(negedge clk_i);
      check("rst_div_busy", bus.md_busy, 1'b0);
      check("rst_div_valid", bus.dn_valid, 1'b0);
      hilo_seen = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk_i);
         hilo_seen += int'(bus.hilo_we || bus.dn_valid);
      end
      check("rst_div_no_result", hilo_seen, 0);

      // Randomized traffic, model checks every cycle.
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk_i);
         #1;
         bus.up_valid = ($urandom_range(0, 3) != 0);
         bus.alu_op   = ($urandom_range(0, 1) != 0) ? 3'b010 : 3'($urandom_range(0, 7));
         bus.funct    = ($urandom_range(0, 4) != 0) ? legal_f[$urandom_range(0, 9)]
                                                    : 6'($urandom_range(0, 63));
         bus.dn_ready = ($urandom_range(0, 9) < 7);
         rst_i        = ($urandom_range(0, 299) == 0);
      end
      @(posedge clk_i);
      #1;
      bus.up_valid = 1'b0;
      bus.dn_ready = 1'b1;
      rst_i        = 1'b0;
      repeat (MD_LAT + 4) @(negedge clk_i);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
